// File: rtl/riscv_multi_fsm_pkg.sv
// Shared types and constants for the multicycle RV32I main controller.
// Holds the FSM state encoding, opcode values, ALU control codes and the
// datapath select codes used by the controller and its ALU decoder.
package riscv_multi_pkg;

  // main controller states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALWB,
    S_LUI,
    S_AUIPC,
    S_ILLEGAL
  } state_t;

  // RV32I major opcodes handled by this core
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes; codes above ALU_SRA are reserved
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_t;

  // immediate formats produced by the extender
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;

  // operation class the FSM asks of the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  // ALU operand and result multiplexer selects
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

  // branch condition from funct3 and the ALU compare flags
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    logic taken;
    case (f3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/riscv_multi_fsm_if.sv
// Controller-to-datapath bundle for the multicycle RV32I core: instruction
// fields and ALU flags in, datapath enables/selects and the ready/valid
// memory request out. master = controller side, slave = datapath/memory side.
interface riscv_multi_fsm_if #(parameter int ALUC_W = 4);

  logic [6:0]        op;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic              zero;
  logic              lt;
  logic              ltu;
  logic              mem_ready;

  logic              mem_req;
  logic              MemWrite;
  logic              AdrSrc;
  logic              IRWrite;
  logic              PCWrite;
  logic              RegWrite;
  logic [2:0]        ImmSrc;
  logic [1:0]        ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic [1:0]        ResultSrc;
  logic [ALUC_W-1:0] ALUControl;
  logic              halted;

  modport master (
    input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, halted
  );

  modport slave (
    output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, halted
  );

endinterface

// File: rtl/riscv_multi_fsm_alu_dec.sv
// ALU decoder: turns the FSM's operation class plus the instruction's
// funct fields into a 4-bit ALU control code. Purely combinational.
import riscv_multi_pkg::*;

module riscv_alu_dec #(
  parameter int ALUC_W = 4
) (
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  alu_op_t           alu_op,
  output logic [ALUC_W-1:0] alu_control
);

  alu_ctrl_t ctrl;

  // select the ALU function; subtract on funct3=000 only for R-type with instr[30]
  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctrl = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign alu_control = ALUC_W'(ctrl);

endmodule

// File: rtl/riscv_multi_fsm.sv
// Main controller for the multicycle RV32I core: instruction decode plus the
// main FSM driving datapath enables/selects and a ready/valid memory port.
// Optional feature macro: RVM_PERF_CNT_EN adds cycle_cnt/instret_cnt outputs.
// While reset is high every output is held at zero; the FSM restarts in FETCH.
import riscv_multi_pkg::*;

module riscv_multi_fsm #(
  parameter int ALUC_W = 4
`ifdef RVM_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  riscv_multi_fsm_if.master  bus
`ifdef RVM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
`endif
);

  state_t   state;
  state_t   next;
  alu_op_t  alu_op;
  imm_src_t imm_src;

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] result_src;
  logic       halted;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // next-state decode and Moore outputs, fetch enables qualified by mem_ready
  always_comb begin
    next       = state;
    alu_op     = ALUOP_ADD;
    imm_src    = IMM_I;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    result_src = RES_ALUOUT;
    halted     = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          src_b      = SRCB_FOUR;
          result_src = RES_ALURESULT;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            next     = S_DECODE;
          end
        end
        S_DECODE: begin
          src_a   = SRCA_OLDPC;
          src_b   = SRCB_IMM;
          imm_src = IMM_B;
          case (bus.op)
            OP_LOAD, OP_STORE: next = (bus.funct3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
            OP_RTYPE:          next = S_EXECR;
            OP_ITYPE:          next = S_EXECI;
            OP_BRANCH:         next = (bus.funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
            OP_JAL:            next = S_JAL;
            OP_JALR:           next = (bus.funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
            OP_LUI:            next = S_LUI;
            OP_AUIPC:          next = S_AUIPC;
            default:           next = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          src_a   = SRCA_RS1;
          src_b   = SRCB_IMM;
          imm_src = (bus.op == OP_STORE) ? IMM_S : IMM_I;
          next    = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (bus.mem_ready) next = S_MEMWB;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (bus.mem_ready) next = S_FETCH;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          next       = S_FETCH;
        end
        S_EXECR: begin
          src_a  = SRCA_RS1;
          src_b  = SRCB_RS2;
          alu_op = ALUOP_FUNCT;
          next   = S_ALUWB;
        end
        S_EXECI: begin
          src_a   = SRCA_RS1;
          src_b   = SRCB_IMM;
          imm_src = IMM_I;
          alu_op  = ALUOP_FUNCT;
          next    = S_ALUWB;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
          next       = S_FETCH;
        end
        S_BRANCH: begin
          src_a      = SRCA_RS1;
          src_b      = SRCB_RS2;
          alu_op     = ALUOP_SUB;
          result_src = RES_ALUOUT;
          pc_write   = branch_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);
          next       = S_FETCH;
        end
        S_JAL: begin
          src_a      = SRCA_OLDPC;
          src_b      = SRCB_FOUR;
          result_src = RES_ALUOUT;
          pc_write   = 1'b1;
          next       = S_ALUWB;
        end
        S_JALR: begin
          src_a      = SRCA_RS1;
          src_b      = SRCB_IMM;
          imm_src    = IMM_I;
          result_src = RES_ALURESULT;
          pc_write   = 1'b1;
          next       = S_JALWB;
        end
        S_JALWB: begin
          src_a      = SRCA_OLDPC;
          src_b      = SRCB_FOUR;
          result_src = RES_ALURESULT;
          reg_write  = 1'b1;
          next       = S_FETCH;
        end
        S_LUI: begin
          src_a   = SRCA_ZERO;
          src_b   = SRCB_IMM;
          imm_src = IMM_U;
          next    = S_ALUWB;
        end
        S_AUIPC: begin
          src_a   = SRCA_OLDPC;
          src_b   = SRCB_IMM;
          imm_src = IMM_U;
          next    = S_ALUWB;
        end
        S_ILLEGAL: begin
          halted = 1'b1;
          next   = S_ILLEGAL;
        end
        default: next = S_ILLEGAL;
      endcase
    end
  end

  riscv_alu_dec #(.ALUC_W(ALUC_W)) u_alu_dec (
    .op          (bus.op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .alu_op      (alu_op),
    .alu_control (bus.ALUControl)
  );

  assign bus.mem_req   = mem_req;
  assign bus.MemWrite  = mem_write;
  assign bus.AdrSrc    = adr_src;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.RegWrite  = reg_write;
  assign bus.ImmSrc    = imm_src;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ResultSrc = result_src;
  assign bus.halted    = halted;

`ifdef RVM_PERF_CNT_EN
  // cycle count while running, retired count on every return to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_ILLEGAL) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (next == S_FETCH && state != S_FETCH) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
